// File: rtl/dram_page_tracker.sv
// DRAM page tracker: decodes a request address, classifies it against a
// 16-entry open-row table as HIT/MISS/EMPTY, launches one issue pulse per
// request and keeps saturating hit/miss/empty statistics.
//
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   req_valid/req_ready              request handshake (ready only in IDLE)
//   req_addr[32:0], req_rd_wr        physical byte address, 0=read 1=write
//   issue_en                         one-cycle launch pulse
//   issue_rd_wr, issue_bank_group,
//   issue_bank, issue_row,
//   issue_column                     decoded fields of the issued command
//   issue_policy                     HIT/MISS/EMPTY, NULL when idle
//   issue_different_bg/_b            bank group / bank changed since last cmd
//   cmd_done                         downstream command completed
//   hit_count, miss_count,
//   empty_count                      saturating statistics counters

package dram_page_tracker_pkg;
    typedef enum logic [1:0] {
        POL_NULL  = 2'd0,
        POL_HIT   = 2'd1,
        POL_MISS  = 2'd2,
        POL_EMPTY = 2'd3
    } dram_policy_t;
endpackage

module dram_page_tracker
    import dram_page_tracker_pkg::*;
#(
    parameter int unsigned CLOSED_PAGE = 0,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [32:0]      req_addr,
    input  logic             req_rd_wr,
    output logic             issue_en,
    output logic             issue_rd_wr,
    output logic [1:0]       issue_bank_group,
    output logic [1:0]       issue_bank,
    output logic [14:0]      issue_row,
    output logic [10:0]      issue_column,
    output dram_policy_t     issue_policy,
    output logic             issue_different_bg,
    output logic             issue_different_b,
    input  logic             cmd_done,
    output logic [CNT_W-1:0] hit_count,
    output logic [CNT_W-1:0] miss_count,
    output logic [CNT_W-1:0] empty_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DECODE,
        S_ISSUE,
        S_WAIT_DONE
    } state_t;

    state_t       state_q;
    state_t       state_d;

    // Byte offset bits are never stored.
    logic [32:3]  addr_q;
    logic         rd_wr_q;
    dram_policy_t policy_q;
    logic         diff_bg_q;
    logic         diff_b_q;
    logic         first_q;
    logic [1:0]   last_bg;
    logic [1:0]   last_bank;
    logic [15:0]  open_flag;
    logic [14:0]  open_row [16];

    logic [14:0]  a_row;
    logic [10:0]  a_col;
    logic [1:0]   a_bank;
    logic [1:0]   a_bg;
    logic [3:0]   idx;
    dram_policy_t cls;
    logic         unused_addr;

    assign unused_addr = ^req_addr[2:0];

    assign a_row  = addr_q[32:18];
    assign a_col  = {addr_q[17:10], addr_q[5:3]};
    assign a_bank = addr_q[9:8];
    assign a_bg   = addr_q[7:6];
    assign idx    = {a_bg, a_bank};

    always_comb begin
        cls = POL_EMPTY;
        if (open_flag[idx]) begin
            cls = (open_row[idx] == a_row) ? POL_HIT : POL_MISS;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // cmd_done is only looked at in WAIT_DONE, so a completion that
    // coincides with DECODE or the ISSUE pulse is dropped.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      if (req_valid) state_d = S_DECODE;
            S_DECODE:    state_d = S_ISSUE;
            S_ISSUE:     state_d = S_WAIT_DONE;
            S_WAIT_DONE: if (cmd_done) state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q      <= '0;
            rd_wr_q     <= 1'b0;
            policy_q    <= POL_NULL;
            diff_bg_q   <= 1'b0;
            diff_b_q    <= 1'b0;
            first_q     <= 1'b1;
            last_bg     <= 2'd0;
            last_bank   <= 2'd0;
            open_flag   <= '0;
            hit_count   <= '0;
            miss_count  <= '0;
            empty_count <= '0;
            for (int i = 0; i < 16; i++) begin
                open_row[i] <= '0;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        addr_q  <= req_addr[32:3];
                        rd_wr_q <= req_rd_wr;
                    end
                end
                S_DECODE: begin
                    policy_q  <= cls;
                    diff_bg_q <= !first_q && (a_bg != last_bg);
                    diff_b_q  <= !first_q && (a_bank != last_bank);
                end
                S_ISSUE: begin
                    open_flag[idx] <= 1'b1;
                    open_row[idx]  <= a_row;
                    last_bg        <= a_bg;
                    last_bank      <= a_bank;
                    first_q        <= 1'b0;
                    case (policy_q)
                        POL_HIT:
                            if (hit_count != '1)
                                hit_count <= hit_count + CNT_W'(1);
                        POL_MISS:
                            if (miss_count != '1)
                                miss_count <= miss_count + CNT_W'(1);
                        POL_EMPTY:
                            if (empty_count != '1)
                                empty_count <= empty_count + CNT_W'(1);
                        default: ;
                    endcase
                end
                S_WAIT_DONE: begin
                    if (cmd_done) begin
                        policy_q <= POL_NULL;
                        if (CLOSED_PAGE != 0) begin
                            open_flag[idx] <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign req_ready          = (state_q == S_IDLE);
    assign issue_en           = (state_q == S_ISSUE);
    assign issue_rd_wr        = rd_wr_q;
    assign issue_bank_group   = a_bg;
    assign issue_bank         = a_bank;
    assign issue_row          = a_row;
    assign issue_column       = a_col;
    assign issue_policy       = policy_q;
    assign issue_different_bg = diff_bg_q;
    assign issue_different_b  = diff_b_q;

endmodule

// File: tb/tb_dram_page_tracker.sv
// Testbench for dram_page_tracker: an open-page and a closed-page instance
// (2-bit counters) share stimulus and are checked against a reference model.

module tb_dram_page_tracker;
    import dram_page_tracker_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        req_valid = 1'b0;
    logic [32:0] req_addr = '0;
    logic        req_rd_wr = 1'b0;
    logic        cmd_done = 1'b0;

    logic         o_req_ready, o_issue_en, o_issue_rd_wr;
    logic [1:0]   o_bg, o_bank;
    logic [14:0]  o_row;
    logic [10:0]  o_col;
    dram_policy_t o_pol;
    logic         o_dbg, o_db;
    logic [31:0]  o_hit, o_miss, o_empty;

    logic         c_req_ready, c_issue_en, c_issue_rd_wr;
    logic [1:0]   c_bg, c_bank;
    logic [14:0]  c_row;
    logic [10:0]  c_col;
    dram_policy_t c_pol;
    logic         c_dbg, c_db;
    logic [1:0]   c_hit, c_miss, c_empty;

    dram_page_tracker #(.CLOSED_PAGE(0), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(o_req_ready),
        .req_addr(req_addr), .req_rd_wr(req_rd_wr),
        .issue_en(o_issue_en), .issue_rd_wr(o_issue_rd_wr),
        .issue_bank_group(o_bg), .issue_bank(o_bank),
        .issue_row(o_row), .issue_column(o_col),
        .issue_policy(o_pol),
        .issue_different_bg(o_dbg), .issue_different_b(o_db),
        .cmd_done(cmd_done),
        .hit_count(o_hit), .miss_count(o_miss), .empty_count(o_empty)
    );

    dram_page_tracker #(.CLOSED_PAGE(1), .CNT_W(2)) dut_c (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(c_req_ready),
        .req_addr(req_addr), .req_rd_wr(req_rd_wr),
        .issue_en(c_issue_en), .issue_rd_wr(c_issue_rd_wr),
        .issue_bank_group(c_bg), .issue_bank(c_bank),
        .issue_row(c_row), .issue_column(c_col),
        .issue_policy(c_pol),
        .issue_different_bg(c_dbg), .issue_different_b(c_db),
        .cmd_done(cmd_done),
        .hit_count(c_hit), .miss_count(c_miss), .empty_count(c_empty)
    );

    typedef struct {
        int           hs;
        logic         rw;
        logic [1:0]   bg;
        logic [1:0]   bank;
        logic [14:0]  row;
        logic [10:0]  col;
        dram_policy_t pol;
        logic         dbg;
        logic         db;
    } exp_t;

    exp_t sbq[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;

    always @(posedge clk) cyc++;

    // Reference model: which row each bank holds open (open-page view).
    bit          m_open [16];
    logic [14:0] m_row  [16];
    logic [1:0]  m_lbg, m_lb;
    bit          m_first;
    int          m_hit, m_miss, m_empty, m_total;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)",
                     nm, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 16; i++) begin
            m_open[i] = 1'b0;
            m_row[i]  = '0;
        end
        m_lbg = 0; m_lb = 0; m_first = 1'b1;
        m_hit = 0; m_miss = 0; m_empty = 0; m_total = 0;
    endfunction

    function automatic exp_t model_issue(input logic [32:0] a,
                                         input logic rw, input int hs);
        exp_t e;
        int   k;
        e.hs   = hs;
        e.rw   = rw;
        e.row  = a[32:18];
        e.col  = {a[17:10], a[5:3]};
        e.bank = a[9:8];
        e.bg   = a[7:6];
        k = int'(e.bg) * 4 + int'(e.bank);
        if (!m_open[k]) e.pol = POL_EMPTY;
        else if (m_row[k] == e.row) e.pol = POL_HIT;
        else e.pol = POL_MISS;
        e.dbg = m_first ? 1'b0 : (e.bg != m_lbg);
        e.db  = m_first ? 1'b0 : (e.bank != m_lb);
        m_open[k] = 1'b1;
        m_row[k]  = e.row;
        m_lbg = e.bg; m_lb = e.bank; m_first = 1'b0;
        m_total++;
        if (e.pol == POL_HIT) m_hit++;
        else if (e.pol == POL_MISS) m_miss++;
        else m_empty++;
        return e;
    endfunction

    // Monitor: every issue pulse pops one expectation.
    always @(negedge clk) begin : mon
        exp_t e;
        if (rst_n && (o_issue_en || c_issue_en)) begin
            chk("issue_en_pair", 64'(c_issue_en), 64'(o_issue_en));
            if (sbq.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_issue: got pulse expected none (t=%0t)",
                         $time);
            end else begin
                e = sbq.pop_front();
                chk("latency", 64'(cyc), 64'(e.hs + 2));
                chk("rd_wr", 64'(o_issue_rd_wr), 64'(e.rw));
                chk("bg", 64'(o_bg), 64'(e.bg));
                chk("bank", 64'(o_bank), 64'(e.bank));
                chk("row", 64'(o_row), 64'(e.row));
                chk("col", 64'(o_col), 64'(e.col));
                chk("policy", 64'(o_pol), 64'(e.pol));
                chk("diff_bg", 64'(o_dbg), 64'(e.dbg));
                chk("diff_b", 64'(o_db), 64'(e.db));
                chk("c_policy", 64'(c_pol), 64'(POL_EMPTY));
                chk("c_row", 64'(c_row), 64'(e.row));
            end
        end
    end

    task automatic chk_cnt();
        chk("hit_count", 64'(o_hit), 64'(m_hit));
        chk("miss_count", 64'(o_miss), 64'(m_miss));
        chk("empty_count", 64'(o_empty), 64'(m_empty));
        chk("c_hit_count", 64'(c_hit), 64'd0);
        chk("c_miss_count", 64'(c_miss), 64'd0);
        chk("c_empty_sat", 64'(c_empty), 64'((m_total > 3) ? 3 : m_total));
    endtask

    task automatic do_reset();
        cmd_done  = 1'b0;
        req_valid = 1'b0;
        rst_n     = 1'b0;
        #1;
        chk("rst_ready", 64'(o_req_ready), 64'd1);
        chk("rst_issue_en", 64'(o_issue_en), 64'd0);
        chk("rst_policy", 64'(o_pol), 64'(POL_NULL));
        chk("rst_c_policy", 64'(c_pol), 64'(POL_NULL));
        chk("rst_fields", {o_bg, o_bank, o_row, o_col, o_dbg, o_db,
                           o_issue_rd_wr}, 64'd0);
        chk("rst_counts", {o_hit, o_miss}, 64'd0);
        chk("rst_empty", {o_empty, c_empty}, 64'd0);
        chk("sb_empty_at_reset", 64'(sbq.size()), 64'd0);
        model_reset();
        sbq.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    // early: 1 = cmd_done during DECODE, 2 = during ISSUE
    // rst_at: 1 = reset in DECODE, 2 = reset in WAIT_DONE
    task automatic do_req(input logic [32:0] a, input logic rw,
                          input int early, input int wn, input bit hold,
                          input int rst_at);
        int   hs;
        int   k;
        exp_t e;
        k = 0;
        while (!o_req_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("ready_before_req", 64'(o_req_ready), 64'd1);
        req_valid = 1'b1;
        req_addr  = a;
        req_rd_wr = rw;
        hs = cyc;
        @(negedge clk);
        if (!hold) req_valid = 1'b0;
        req_addr  = 33'($urandom);
        req_rd_wr = 1'($urandom);
        if (rst_at == 1) begin
            do_reset();
            return;
        end
        e = model_issue(a, rw, hs);
        sbq.push_back(e);
        chk("ready_in_decode", 64'(o_req_ready), 64'd0);
        if (early == 1) cmd_done = 1'b1;
        @(negedge clk);
        cmd_done = (early == 2);
        @(negedge clk);
        cmd_done = 1'b0;
        chk("sb_consumed", 64'(sbq.size()), 64'd0);
        for (int i = 0; i < wn; i++) begin
            chk("ready_in_wait", 64'(o_req_ready), 64'd0);
            chk("hold_policy", 64'(o_pol), 64'(e.pol));
            chk("hold_row", 64'(o_row), 64'(e.row));
            @(negedge clk);
        end
        if (rst_at == 2) begin
            chk("policy_before_rst", 64'(o_pol), 64'(e.pol));
            do_reset();
            return;
        end
        cmd_done = 1'b1;
        @(negedge clk);
        cmd_done  = 1'b0;
        req_valid = 1'b0;
        chk("ready_after_done", 64'(o_req_ready), 64'd1);
        chk("policy_null_idle", 64'(o_pol), 64'(POL_NULL));
        chk("c_policy_null_idle", 64'(c_pol), 64'(POL_NULL));
        chk_cnt();
    endtask

    function automatic logic [32:0] rand_addr();
        logic [14:0] r;
        logic [10:0] c;
        logic [3:0]  b;
        int          sel;
        sel = $urandom_range(0, 4);
        r = (sel < 3) ? 15'(sel) : 15'($urandom);
        c = 11'($urandom);
        b = 4'($urandom);
        return {r, c[10:3], b[1:0], b[3:2], c[2:0], 3'($urandom)};
    endfunction

    initial begin
        model_reset();
        @(negedge clk);
        do_reset();

        // First command after reset
        do_req(33'h0, 1'b0, 0, 1, 1'b0, 0);
        chk("first_empty_count", 64'(o_empty), 64'd1);

        // Open-page HIT / MISS / HIT sequence
        do_req(33'h0, 1'b1, 0, 0, 1'b0, 0);
        do_req(33'h40000, 1'b0, 0, 2, 1'b0, 0);
        do_req(33'h40000, 1'b0, 0, 0, 1'b0, 0);
        chk("seq_hit_count", 64'(o_hit), 64'd2);
        chk("seq_miss_count", 64'(o_miss), 64'd1);
        chk("c_seq_hit_count", 64'(c_hit), 64'd0);

        // Bank group / bank change flags
        do_reset();
        do_req(33'h0, 1'b0, 0, 0, 1'b0, 0);
        do_req(33'h40, 1'b0, 0, 0, 1'b0, 0);
        do_req(33'h140, 1'b1, 0, 0, 1'b0, 0);
        chk("flags_empty_count", 64'(o_empty), 64'd3);

        // Handshake: valid held in WAIT_DONE, cmd_done in DECODE and ISSUE
        do_req(33'h80, 1'b0, 1, 3, 1'b1, 0);
        do_req(33'h80, 1'b1, 2, 2, 1'b1, 0);

        // Reset in WAIT_DONE, then the same address again
        do_reset();
        do_req(33'h0_1234_5678, 1'b0, 0, 2, 1'b0, 2);
        do_req(33'h0_1234_5678, 1'b0, 0, 0, 1'b0, 0);
        chk("after_rst_empty_count", 64'(o_empty), 64'd1);

        // Reset while in DECODE abandons the request
        do_req(33'h0_1234_5678, 1'b1, 0, 0, 1'b0, 1);
        chk("abort_empty_count", 64'(o_empty), 64'd0);

        // Randomized traffic
        for (int n = 0; n < 150; n++) begin
            int ra;
            ra = $urandom_range(0, 29);
            do_req(rand_addr(), 1'($urandom),
                   $urandom_range(0, 2), $urandom_range(0, 3),
                   1'($urandom_range(0, 1)),
                   (ra == 0) ? 1 : (ra == 1) ? 2 : 0);
        end
        chk("final_sb_empty", 64'(sbq.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
